// File: rtl/bram_arbiter.sv
// Three-port round-robin arbiter for a single-port BRAM (loader, fetch, write-back).
// Grants follow the registered owner; read returns are tagged and delivered RD_LAT cycles later.
module bram_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,

  input  logic              ft_req_i,
  input  logic              ft_we_i,
  input  logic [ADDR_W-1:0] ft_addr_i,
  input  logic [DATA_W-1:0] ft_wdata_i,
  output logic              ft_gnt_o,
  output logic              ft_rvalid_o,

  input  logic              wb_req_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  output logic              wb_gnt_o,
  output logic              wb_rvalid_o,

  output logic [DATA_W-1:0] rdata_o,

  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] dina_o,
  input  logic [DATA_W-1:0] douta_i,

  output logic [1:0]        owner_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_LD = 2'd1,
    OWN_FT = 2'd2,
    OWN_WB = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t      state, state_nxt;
  state_t      last_owner, last_owner_nxt;
  state_t      pick;
  logic [7:0]  beat_cnt, beat_cnt_nxt;

  logic              own_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              beat;
  logic              release_own;

  logic [RD_LAT-1:0]      rv_pipe;
  logic [RD_LAT-1:0][1:0] rid_pipe;

  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state)
      OWN_LD: begin
        own_req   = ld_req_i;
        own_we    = ld_we_i;
        own_addr  = ld_addr_i;
        own_wdata = ld_wdata_i;
      end
      OWN_FT: begin
        own_req   = ft_req_i;
        own_we    = ft_we_i;
        own_addr  = ft_addr_i;
        own_wdata = ft_wdata_i;
      end
      OWN_WB: begin
        own_req   = wb_req_i;
        own_we    = wb_we_i;
        own_addr  = wb_addr_i;
        own_wdata = wb_wdata_i;
      end
      default: ;
    endcase
  end

  assign ld_gnt_o = (state == OWN_LD) && ld_req_i;
  assign ft_gnt_o = (state == OWN_FT) && ft_req_i;
  assign wb_gnt_o = (state == OWN_WB) && wb_req_i;
  assign beat     = ld_gnt_o | ft_gnt_o | wb_gnt_o;

  assign ena_o   = beat;
  assign wea_o   = beat & own_we;
  assign addr_o  = beat ? own_addr  : '0;
  assign dina_o  = beat ? own_wdata : '0;
  assign rdata_o = douta_i;
  assign owner_o = state;

  // Search starts after the last owner, so a port that just exhausted its burst comes last.
  always_comb begin
    pick = IDLE;
    case (last_owner)
      OWN_LD: begin
        if      (ft_req_i) pick = OWN_FT;
        else if (wb_req_i) pick = OWN_WB;
        else if (ld_req_i) pick = OWN_LD;
      end
      OWN_FT: begin
        if      (wb_req_i) pick = OWN_WB;
        else if (ld_req_i) pick = OWN_LD;
        else if (ft_req_i) pick = OWN_FT;
      end
      default: begin
        if      (ld_req_i) pick = OWN_LD;
        else if (ft_req_i) pick = OWN_FT;
        else if (wb_req_i) pick = OWN_WB;
      end
    endcase
  end

  assign release_own = (state == IDLE) || !own_req || (beat && (beat_cnt == LAST_BEAT));

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    if (beat) beat_cnt_nxt = beat_cnt + 8'd1;
    if (release_own) begin
      state_nxt = pick;
      if (pick != IDLE) begin
        last_owner_nxt = pick;
        beat_cnt_nxt   = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWN_WB;
      beat_cnt   <= 8'd0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Returns carry the issuing port id, so they survive ownership changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_pipe  <= '0;
      rid_pipe <= '0;
    end else begin
      rv_pipe[0]  <= beat && !own_we;
      rid_pipe[0] <= state;
      for (int i = 1; i < RD_LAT; i++) begin
        rv_pipe[i]  <= rv_pipe[i-1];
        rid_pipe[i] <= rid_pipe[i-1];
      end
    end
  end

  assign ld_rvalid_o = rv_pipe[RD_LAT-1] && (rid_pipe[RD_LAT-1] == 2'd1);
  assign ft_rvalid_o = rv_pipe[RD_LAT-1] && (rid_pipe[RD_LAT-1] == 2'd2);
  assign wb_rvalid_o = rv_pipe[RD_LAT-1] && (rid_pipe[RD_LAT-1] == 2'd3);

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: table vectors, directed multi-cycle sequences and random traffic
// checked cycle by cycle against a port-level ownership model with a BRAM model attached.
module tb_bram_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int RL = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:1]    req, we, gnt, rv;
  logic [AW-1:0] addr  [1:3];
  logic [DW-1:0] wdata [1:3];
  logic [DW-1:0] rdata, dina, douta;
  logic          ena, wea;
  logic [AW-1:0] addr_o;
  logic [1:0]    owner;

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .ld_req_i(req[1]), .ld_we_i(we[1]), .ld_addr_i(addr[1]), .ld_wdata_i(wdata[1]),
    .ld_gnt_o(gnt[1]), .ld_rvalid_o(rv[1]),
    .ft_req_i(req[2]), .ft_we_i(we[2]), .ft_addr_i(addr[2]), .ft_wdata_i(wdata[2]),
    .ft_gnt_o(gnt[2]), .ft_rvalid_o(rv[2]),
    .wb_req_i(req[3]), .wb_we_i(we[3]), .wb_addr_i(addr[3]), .wb_wdata_i(wdata[3]),
    .wb_gnt_o(gnt[3]), .wb_rvalid_o(rv[3]),
    .rdata_o(rdata),
    .ena_o(ena), .wea_o(wea), .addr_o(addr_o), .dina_o(dina), .douta_i(douta),
    .owner_o(owner)
  );

  // BRAM: 1024 words visible, read data after RL cycles
  logic [DW-1:0] mem    [1024];
  logic [DW-1:0] shadow [1024];
  logic [DW-1:0] dpipe  [RL];
  always @(posedge clk) begin
    if (ena && wea) mem[addr_o[9:0]] <= dina;
    dpipe[0] <= mem[addr_o[9:0]];
    for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign douta = dpipe[RL-1];

  function automatic logic [DW-1:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } ret_t;

  int   m_owner, m_last, m_cnt, cyc;
  ret_t rq[$];
  int   errors = 0;
  int   checks = 0;

  logic [3:1]    s_gnt, s_rv;
  int            s_owner;
  logic [DW-1:0] s_rdata;
  logic          s_ena;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic ebeat);
    int rel, nxt, p, o;
    if (rst) begin
      m_owner = 0; m_last = 3; m_cnt = 0;
      rq.delete();
    end else begin
      o   = m_owner;
      rel = (o == 0) || !req[o] || (ebeat && m_cnt == MB - 1);
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (ebeat) begin
        m_cnt++;
        if (we[o]) shadow[addr[o][9:0]] = wdata[o];
        else rq.push_back('{due: cyc + RL, port: o, data: shadow[addr[o][9:0]]});
      end
      if (rel) begin
        nxt = 0;
        for (int k = 1; k <= 3; k++) begin
          p = (m_last + k - 1) % 3 + 1;
          if (nxt == 0 && req[p]) nxt = p;
        end
        m_owner = nxt;
        if (nxt != 0) begin
          m_last = nxt;
          m_cnt  = 0;
        end
      end
    end
    cyc++;
  endtask

  // Called at posedge+1 with inputs set; compares at the falling edge, then advances a cycle.
  task automatic tick(input bit chk);
    logic [3:1]    eg, erv;
    logic          ebeat;
    logic [DW-1:0] erd;
    int            o;
    #4;
    eg = '0;
    for (int p = 1; p <= 3; p++) eg[p] = (m_owner == p) && req[p];
    ebeat = |eg;
    o     = (m_owner == 0) ? 1 : m_owner;
    erv   = '0;
    erd   = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      erv[rq[0].port] = 1'b1;
      erd = rq[0].data;
    end
    s_gnt = gnt; s_rv = rv; s_owner = int'(owner); s_rdata = rdata; s_ena = ena;
    if (chk) begin
      check("gnt",    32'(gnt),    32'(eg));
      check("ena",    32'(ena),    32'(ebeat));
      check("wea",    32'(wea),    32'(ebeat ? we[o] : 1'b0));
      check("addr",   32'(addr_o), 32'(ebeat ? addr[o] : '0));
      check("dina",   32'(dina),   32'(ebeat ? wdata[o] : '0));
      check("owner",  32'(owner),  32'(m_owner));
      check("rvalid", 32'(rv),     32'(erv));
      if (|erv) check("rdata", 32'(rdata), 32'(erd));
    end
    model_step(ebeat);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int p = 1; p <= 3; p++) begin
      we[p]    = 1'($urandom_range(0, 1));
      addr[p]  = AW'($urandom_range(0, 1023));
      wdata[p] = DW'($urandom);
    end
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    req = '0;
    tick(chk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:1] req;
    logic [3:1] gnt;
    logic [1:0] owner;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int n, first, last, bad, ena_n, rv_n, fg, frv, got;
    int glist[$];
    // req/gnt bits are {wb, ft, ld}
    tbl[0]  = '{3'b000, 3'b000, 2'd0};
    tbl[1]  = '{3'b010, 3'b000, 2'd0};
    tbl[2]  = '{3'b010, 3'b010, 2'd2};
    tbl[3]  = '{3'b111, 3'b010, 2'd2};
    tbl[4]  = '{3'b101, 3'b000, 2'd2};
    tbl[5]  = '{3'b101, 3'b100, 2'd3};
    tbl[6]  = '{3'b001, 3'b000, 2'd3};
    tbl[7]  = '{3'b000, 3'b000, 2'd1};
    tbl[8]  = '{3'b100, 3'b000, 2'd0};
    tbl[9]  = '{3'b110, 3'b100, 2'd3};
    tbl[10] = '{3'b010, 3'b000, 2'd3};
    tbl[11] = '{3'b010, 3'b010, 2'd2};

    for (int i = 0; i < 1024; i++) begin
      mem[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
    m_owner = 0; m_last = 3; m_cnt = 0; cyc = 0;
    req = '0; we = '0;
    for (int p = 1; p <= 3; p++) begin
      addr[p] = '0; wdata[p] = '0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // table vectors from reset
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      tick(1'b1);
      check($sformatf("tbl%0d_gnt", i),   32'(s_gnt),   32'(tbl[i].gnt));
      check($sformatf("tbl%0d_owner", i), 32'(s_owner), 32'(tbl[i].owner));
      check($sformatf("tbl%0d_ena", i),   32'(s_ena),   32'(|tbl[i].gnt));
    end

    // ft read burst of 4 at addresses 0..3
    do_reset(1'b1);
    we = '0; req[2] = 1'b1; addr[2] = '0;
    n = 0; ena_n = 0; rv_n = 0; fg = -1; frv = -1;
    for (int t = 0; t < 12; t++) begin
      tick(1'b1);
      if (s_ena) ena_n++;
      if (s_gnt[2]) begin
        if (fg < 0) fg = t;
        n++;
      end
      if (s_rv[2]) begin
        if (frv < 0) frv = t;
        check("burst_rdata", 32'(s_rdata), 32'(init_val(rv_n)));
        rv_n++;
      end
      if (n == 4) req[2] = 1'b0;
      addr[2] = AW'(n);
    end
    check("burst_ena_cycles", 32'(ena_n), 32'd4);
    check("burst_rvalid_cycles", 32'(rv_n), 32'd4);
    check("burst_rvalid_lag", 32'(frv - fg), 32'(RL));

    // all three requesting from reset: 16-beat tenures with no bubbles
    do_reset(1'b1);
    req = 3'b111;
    glist.delete();
    for (int t = 0; t < 66; t++) begin
      rand_data();
      tick(1'b1);
      if (s_gnt != 3'b000) glist.push_back(s_gnt[1] ? 1 : s_gnt[2] ? 2 : 3);
    end
    req = '0;
    check("rr_grant_count", 32'(glist.size()), 32'd65);
    if (glist.size() == 65) begin
      check("rr_beat0",  32'(glist[0]),  32'd1);
      check("rr_beat15", 32'(glist[15]), 32'd1);
      check("rr_beat16", 32'(glist[16]), 32'd2);
      check("rr_beat32", 32'(glist[32]), 32'd3);
      check("rr_beat48", 32'(glist[48]), 32'd1);
      check("rr_beat64", 32'(glist[64]), 32'd2);
    end

    // ld writes 0xA5 to 540, then ft reads it back
    do_reset(1'b1);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = AW'(540); wdata[1] = 8'hA5;
    got = 0;
    for (int t = 0; t < 10; t++) if (!got) begin
      tick(1'b1);
      if (s_gnt[1]) got = 1;
    end
    check("wr540_granted", 32'(got), 32'd1);
    req[1] = 1'b0; req[2] = 1'b1; we[2] = 1'b0; addr[2] = AW'(540);
    got = 0;
    for (int t = 0; t < 10; t++) if (!got) begin
      tick(1'b1);
      if (s_gnt[2]) got = 1;
    end
    check("rd540_granted", 32'(got), 32'd1);
    req[2] = 1'b0;
    tick(1'b1);
    check("rd540_rvalid", 32'(s_rv), 32'b010);
    check("rd540_rdata", 32'(s_rdata), 32'hA5);

    // wb alone for 40 beats across two burst boundaries
    do_reset(1'b1);
    req[3] = 1'b1;
    n = 0; first = -1; last = -1; bad = 0;
    for (int t = 0; t < 60; t++) if (n < 40) begin
      rand_data();
      tick(1'b1);
      if (s_gnt[3]) begin
        if (first < 0) first = t;
        last = t;
        n++;
      end
      if (first >= 0 && s_owner != 3) bad++;
    end
    req = '0;
    check("wb40_beats", 32'(n), 32'd40);
    check("wb40_span", 32'(last - first), 32'd39);
    check("wb40_owner_changes", 32'(bad), 32'd0);

    // ft drops after 3 beats while wb waits
    do_reset(1'b1);
    we = '0; req[2] = 1'b1; req[3] = 1'b1;
    n = 0; rv_n = 0;
    for (int t = 0; t < 10; t++) if (n < 3) begin
      tick(1'b1);
      if (s_gnt[2]) n++;
      if (s_rv[2]) rv_n++;
    end
    check("drop_ft_beats", 32'(n), 32'd3);
    req[2] = 1'b0;
    tick(1'b1);
    if (s_rv[2]) rv_n++;
    check("drop_owner_before", 32'(s_owner), 32'd2);
    check("drop_gnt_none", 32'(s_gnt), 32'd0);
    tick(1'b1);
    if (s_rv[2]) rv_n++;
    check("drop_owner_after", 32'(s_owner), 32'd3);
    check("drop_wb_gnt", 32'(s_gnt), 32'b100);
    req[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(1'b1);
      if (s_rv[2]) rv_n++;
    end
    check("drop_ft_rvalids", 32'(rv_n), 32'd3);

    // reset during an ft burst with a read in flight
    do_reset(1'b1);
    we = '0; req[2] = 1'b1;
    n = 0;
    for (int t = 0; t < 10; t++) if (n < 2) begin
      tick(1'b1);
      if (s_gnt[2]) n++;
    end
    rst = 1'b1;
    tick(1'b1);
    check("rst_inflight_beat", 32'(s_gnt), 32'b010);
    rst = 1'b0;
    req = 3'b111;
    tick(1'b1);
    check("rst_owner", 32'(s_owner), 32'd0);
    check("rst_no_rvalid", 32'(s_rv), 32'd0);
    check("rst_no_gnt", 32'(s_gnt), 32'd0);
    tick(1'b1);
    check("rst_ld_first", 32'(s_gnt), 32'b001);
    check("rst_owner_ld", 32'(s_owner), 32'd1);
    check("rst_no_rvalid2", 32'(s_rv), 32'd0);
    req = '0;

    // random traffic with occasional resets
    for (int t = 0; t < 3000; t++) begin
      for (int p = 1; p <= 3; p++) if ($urandom_range(0, 7) == 0) req[p] = ~req[p];
      rand_data();
      rst = ($urandom_range(0, 499) == 0);
      tick(1'b1);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
